// File: rtl/stream_unpacker_pkg.sv
// ============================================================================
// Module      : stream_unpacker_pkg
// Description : Shared FSM state type and chunk-count helper for stream_unpacker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_unpacker_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } unpack_state_t;

  function automatic int nchunk(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_unpacker_if.sv
// ============================================================================
// Module      : stream_unpacker_if
// Description : Wide-word input and narrow-chunk output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_unpacker_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 4
);

  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  // master: the environment (word producer and chunk consumer)
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // slave: the unpacker itself
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

`default_nettype wire

// File: rtl/stream_unpacker.sv
// ============================================================================
// Module      : stream_unpacker
// Description : Splits each IN_WIDTH word into IN_WIDTH/OUT_WIDTH chunks.
//               Define STREAM_UNPACKER_MSB_FIRST_EN to emit the top chunk first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_unpacker
  import stream_unpacker_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  stream_unpacker_if.slave bus
);

  localparam int NCHUNK = nchunk(IN_WIDTH, OUT_WIDTH);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if (OUT_WIDTH < 1 || (IN_WIDTH % OUT_WIDTH) != 0 || NCHUNK < 2) begin : g_param_check
      $error("stream_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 chunks");
    end
  endgenerate

  unpack_state_t        state;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_next;
  logic [IN_WIDTH-1:0]  hold;

  assign idx_next = idx + 1'b1;

  // Beat k of a word maps to a chunk position; reversed in the MSB-first build.
  function automatic logic [OUT_WIDTH-1:0] chunk_at(input logic [IN_WIDTH-1:0] word,
                                                    input logic [IDX_W-1:0]    k);
    logic [IDX_W-1:0] pos;
`ifdef STREAM_UNPACKER_MSB_FIRST_EN
    pos = LAST_IDX - k;
`else
    pos = k;
`endif
    return word[int'(pos)*OUT_WIDTH +: OUT_WIDTH];
  endfunction

  // The end-of-word beat may hand straight over to the next word.
  assign bus.in_ready = !rst && ((state == IDLE) ||
                                 (state == SEND && bus.out_last && bus.out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      hold          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            hold          <= bus.in_data;
            idx           <= '0;
            state         <= SEND;
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b0;
            bus.out_data  <= chunk_at(bus.in_data, '0);
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (!bus.out_last) begin
              idx          <= idx_next;
              bus.out_last <= (idx_next == LAST_IDX);
              bus.out_data <= chunk_at(hold, idx_next);
            end else if (bus.in_valid) begin
              hold          <= bus.in_data;
              idx           <= '0;
              bus.out_valid <= 1'b1;
              bus.out_last  <= 1'b0;
              bus.out_data  <= chunk_at(bus.in_data, '0);
            end else begin
              state         <= IDLE;
              idx           <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
